dma_pcie_mdma_byp_in_arb: RTL and testbench



---
 rtl/dma_pcie_mdma_byp_in_arb.sv | 127 ++++++++++++
 tb/tb_dma_pcie_mdma_byp_in_arb.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_pcie_mdma_byp_in_arb.sv
// Round-robin aggregator of per-channel bypass-in descriptor FIFOs.
// Define MDMA_BYP_IN_ARB_PRIO_EN to make channel 0 strict-priority.
module dma_pcie_mdma_byp_in_arb #(
   parameter int DSC_W      = 256,
   parameter int CIDX_W     = 16,
   parameter int NUM_CH     = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int CH_W       = $clog2(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_CH*DSC_W-1:0]  s_dsc,
   input  logic [NUM_CH*CIDX_W-1:0] s_cidx,
   input  logic [NUM_CH-1:0]        s_vld,
   output logic [NUM_CH-1:0]        s_rdy,
   output logic [DSC_W-1:0]         m_dsc,
   output logic [CIDX_W-1:0]        m_cidx,
   output logic [CH_W-1:0]          m_ch,
   output logic                     m_vld,
   input  logic                     m_rdy,
   output logic                     fifo_ovf
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = DSC_W + CIDX_W;

   logic [EW-1:0]     mem [NUM_CH][FIFO_DEPTH];
   logic [AW-1:0]     wp  [NUM_CH];
   logic [AW-1:0]     rp  [NUM_CH];
   logic [AW:0]       cnt [NUM_CH];
   logic [NUM_CH-1:0] push;
   logic [NUM_CH-1:0] pop;
   logic [NUM_CH-1:0] ne;
   logic [NUM_CH-1:0] ovf;
   logic [CH_W-1:0]   last;
   logic [CH_W-1:0]   gnt;
   logic [CH_W:0]     sum;
   logic              any;
   logic              load;
   logic [EW-1:0]     head;

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         s_rdy[i] = rst_n && (cnt[i] < (AW+1)'(FIFO_DEPTH));
         push[i]  = s_vld[i] & s_rdy[i];
         ne[i]    = (cnt[i] != '0);
         ovf[i]   = push[i] && (cnt[i] == (AW+1)'(FIFO_DEPTH));
      end
   end

   // Search starts one past the last grant and wraps.
   always_comb begin
      gnt = '0;
      any = 1'b0;
      sum = '0;
`ifdef MDMA_BYP_IN_ARB_PRIO_EN
      if (ne[0]) begin
         any = 1'b1;
      end
`endif
      for (int k = 1; k <= NUM_CH; k++) begin
         sum = {1'b0, last} + (CH_W+1)'(k);
         if (sum >= (CH_W+1)'(NUM_CH)) begin
            sum = sum - (CH_W+1)'(NUM_CH);
         end
         if (!any && ne[sum[CH_W-1:0]]) begin
            gnt = sum[CH_W-1:0];
            any = 1'b1;
         end
      end
   end

   assign load = (!m_vld || m_rdy) && any;
   assign head = mem[gnt][rp[gnt]];

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         pop[i] = load && (gnt == CH_W'(i));
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (push[i]) begin
            mem[i][wp[i]] <= {s_dsc[i*DSC_W +: DSC_W],
                              s_cidx[i*CIDX_W +: CIDX_W]};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            wp[i]  <= '0;
            rp[i]  <= '0;
            cnt[i] <= '0;
         end
         last     <= CH_W'(NUM_CH - 1);
         m_vld    <= 1'b0;
         m_dsc    <= '0;
         m_cidx   <= '0;
         m_ch     <= '0;
         fifo_ovf <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (push[i]) wp[i] <= wp[i] + 1'b1;
            if (pop[i])  rp[i] <= rp[i] + 1'b1;
            cnt[i] <= cnt[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
         end
         if (load) begin
            m_vld  <= 1'b1;
            m_dsc  <= head[EW-1:CIDX_W];
            m_cidx <= head[CIDX_W-1:0];
            m_ch   <= gnt;
`ifdef MDMA_BYP_IN_ARB_PRIO_EN
            if (gnt != '0) last <= gnt;
`else
            last   <= gnt;
`endif
         end else if (m_rdy) begin
            m_vld <= 1'b0;
         end
         if (|ovf) fifo_ovf <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dma_pcie_mdma_byp_in_arb.sv
// Directed self-checking bench for dma_pcie_mdma_byp_in_arb.
// Expectations follow MDMA_BYP_IN_ARB_PRIO_EN when it is defined.
module tb_dma_pcie_mdma_byp_in_arb;

   localparam int DSC_W  = 256;
   localparam int CIDX_W = 16;
   localparam int NUM_CH = 4;
   localparam int FD     = 4;
   localparam int CH_W   = 2;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b1;
   logic [NUM_CH*DSC_W-1:0]  s_dsc = '0;
   logic [NUM_CH*CIDX_W-1:0] s_cidx = '0;
   logic [NUM_CH-1:0]        s_vld = '0;
   logic [NUM_CH-1:0]        s_rdy;
   logic [DSC_W-1:0]         m_dsc;
   logic [CIDX_W-1:0]        m_cidx;
   logic [CH_W-1:0]          m_ch;
   logic                     m_vld;
   logic                     m_rdy = 1'b0;
   logic                     fifo_ovf;

   int checks = 0;
   int failures = 0;

   dma_pcie_mdma_byp_in_arb #(
      .DSC_W(DSC_W), .CIDX_W(CIDX_W), .NUM_CH(NUM_CH), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .rst_n(rst_n), .s_dsc(s_dsc), .s_cidx(s_cidx),
      .s_vld(s_vld), .s_rdy(s_rdy), .m_dsc(m_dsc), .m_cidx(m_cidx),
      .m_ch(m_ch), .m_vld(m_vld), .m_rdy(m_rdy), .fifo_ovf(fifo_ovf)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int ch, input logic [DSC_W-1:0] d,
                         input logic [CIDX_W-1:0] c);
      s_dsc[ch*DSC_W +: DSC_W]    = d;
      s_cidx[ch*CIDX_W +: CIDX_W] = c;
   endtask

   task automatic do_reset();
      s_vld = '0;
      m_rdy = 1'b0;
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (s_rdy !== 4'h0) begin
         failures++;
         $display("FAIL reset_srdy_low got=%0h exp=0", s_rdy);
      end
      checks++;
      if (m_vld !== 1'b0 || m_ch !== '0 || m_cidx !== '0 || m_dsc !== '0) begin
         failures++;
         $display("FAIL reset_m got vld=%0b ch=%0d cidx=%0h exp=0",
                  m_vld, m_ch, m_cidx);
      end
      checks++;
      if (fifo_ovf !== 1'b0) begin
         failures++;
         $display("FAIL reset_ovf got=%0b exp=0", fifo_ovf);
      end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if (s_rdy !== 4'hF || m_vld !== 1'b0) begin
         failures++;
         $display("FAIL reset_release got srdy=%0h vld=%0b exp F/0",
                  s_rdy, m_vld);
      end
   endtask

   task automatic test_single();
      do_reset();
      m_rdy = 1'b1;
      set_ch(2, {32{8'hA5}}, 16'h0010);
      s_vld = 4'b0100;
      tick();
      s_vld = '0;
      checks++;
      if (m_vld !== 1'b0) begin
         failures++;
         $display("FAIL single_latency got vld=%0b exp=0", m_vld);
      end
      tick();
      checks++;
      if (m_vld !== 1'b1 || m_ch !== 2'd2 || m_cidx !== 16'h0010) begin
         failures++;
         $display("FAIL single_beat got vld=%0b ch=%0d cidx=%0h exp 1/2/10",
                  m_vld, m_ch, m_cidx);
      end
      checks++;
      if (m_dsc !== {32{8'hA5}}) begin
         failures++;
         $display("FAIL single_dsc got=%0h exp=a5..a5", m_dsc[31:0]);
      end
      tick();
      checks++;
      if (m_vld !== 1'b0) begin
         failures++;
         $display("FAIL single_drop got vld=%0b exp=0", m_vld);
      end
   endtask

   task automatic test_round_robin();
      int exp;
      do_reset();
      m_rdy = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
         set_ch(i, DSC_W'(32'hD000 + i), CIDX_W'(16'h100 + i));
      end
      s_vld = 4'hF;
      tick();
      for (int n = 0; n < 12; n++) begin
         tick();
`ifdef MDMA_BYP_IN_ARB_PRIO_EN
         exp = 0;
`else
         exp = n % 4;
`endif
         checks++;
         if (m_vld !== 1'b1 || m_ch !== CH_W'(exp)) begin
            failures++;
            $display("FAIL rr_ch[%0d] got vld=%0b ch=%0d exp ch=%0d",
                     n, m_vld, m_ch, exp);
         end
         checks++;
         if (m_cidx !== CIDX_W'(16'h100 + exp) || m_dsc !== DSC_W'(32'hD000 + exp)) begin
            failures++;
            $display("FAIL rr_data[%0d] got cidx=%0h exp=%0h",
                     n, m_cidx, 16'h100 + exp);
         end
      end
      s_vld = '0;
   endtask

   task automatic test_backpressure();
      int n;
      logic rdy;
      do_reset();
      m_rdy = 1'b0;
      n = 0;
      set_ch(1, DSC_W'(32'hBEEF), '0);
      s_vld = 4'b0010;
      for (int c = 0; c < 20; c++) begin
         rdy = s_rdy[1];
         tick();
         if (rdy) n++;
         set_ch(1, DSC_W'(32'hBEEF), CIDX_W'(n));
      end
      checks++;
      if (n !== FD + 1) begin
         failures++;
         $display("FAIL bp_accepted got=%0d exp=%0d", n, FD + 1);
      end
      checks++;
      if (s_rdy[1] !== 1'b0) begin
         failures++;
         $display("FAIL bp_srdy got=%0b exp=0", s_rdy[1]);
      end
      checks++;
      if (m_vld !== 1'b1 || m_ch !== 2'd1 || m_cidx !== 16'd0) begin
         failures++;
         $display("FAIL bp_hold got vld=%0b ch=%0d cidx=%0d exp 1/1/0",
                  m_vld, m_ch, m_cidx);
      end
      s_vld = '0;
      m_rdy = 1'b1;
      for (int k = 0; k < FD + 1; k++) begin
         checks++;
         if (m_vld !== 1'b1 || m_cidx !== CIDX_W'(k)) begin
            failures++;
            $display("FAIL bp_order[%0d] got vld=%0b cidx=%0d exp=%0d",
                     k, m_vld, m_cidx, k);
         end
         tick();
         if (k == 0) begin
            checks++;
            if (s_rdy[1] !== 1'b1) begin
               failures++;
               $display("FAIL bp_srdy_return got=%0b exp=1", s_rdy[1]);
            end
         end
      end
      checks++;
      if (m_vld !== 1'b0 || fifo_ovf !== 1'b0) begin
         failures++;
         $display("FAIL bp_drain got vld=%0b ovf=%0b exp 0/0", m_vld, fifo_ovf);
      end
   endtask

   task automatic test_skip();
      int exp;
      do_reset();
      m_rdy = 1'b1;
      set_ch(0, DSC_W'(32'hA), 16'h000A);
      set_ch(3, DSC_W'(32'hD), 16'h000D);
      s_vld = 4'b1001;
      tick();
      for (int n = 0; n < 8; n++) begin
         tick();
`ifdef MDMA_BYP_IN_ARB_PRIO_EN
         exp = 0;
`else
         exp = (n % 2 == 0) ? 0 : 3;
`endif
         checks++;
         if (m_vld !== 1'b1 || m_ch !== CH_W'(exp)) begin
            failures++;
            $display("FAIL skip_ch[%0d] got vld=%0b ch=%0d exp=%0d",
                     n, m_vld, m_ch, exp);
         end
      end
      s_vld = '0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      m_rdy = 1'b0;
      set_ch(0, DSC_W'(32'h1), 16'h0001);
      set_ch(1, DSC_W'(32'h2), 16'h0002);
      s_vld = 4'b0011;
      tick();
      tick();
      tick();
      s_vld = '0;
      checks++;
      if (m_vld !== 1'b1 || s_rdy !== 4'hF) begin
         failures++;
         $display("FAIL mid_setup got vld=%0b srdy=%0h exp 1/F", m_vld, s_rdy);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (m_vld !== 1'b0 || s_rdy !== 4'h0) begin
         failures++;
         $display("FAIL mid_async got vld=%0b srdy=%0h exp 0/0", m_vld, s_rdy);
      end
      tick();
      rst_n = 1'b1;
      #1;
      checks++;
      if (s_rdy !== 4'hF) begin
         failures++;
         $display("FAIL mid_release got srdy=%0h exp=F", s_rdy);
      end
      m_rdy = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++;
         if (m_vld !== 1'b0) begin
            failures++;
            $display("FAIL mid_stale[%0d] got vld=%0b ch=%0d exp vld=0",
                     c, m_vld, m_ch);
         end
      end
   endtask

`ifdef MDMA_BYP_IN_ARB_PRIO_EN
   task automatic test_prio();
      do_reset();
      m_rdy = 1'b1;
      set_ch(0, DSC_W'(32'h10), 16'h0010);
      set_ch(1, DSC_W'(32'h11), 16'h0011);
      s_vld = 4'b0011;
      tick();
      for (int n = 0; n < 6; n++) begin
         tick();
         checks++;
         if (m_vld !== 1'b1 || m_ch !== 2'd0) begin
            failures++;
            $display("FAIL prio_ch0[%0d] got vld=%0b ch=%0d exp=0",
                     n, m_vld, m_ch);
         end
      end
      s_vld = 4'b0010;
      tick();
      checks++;
      if (m_ch !== 2'd0) begin
         failures++;
         $display("FAIL prio_tail got ch=%0d exp=0", m_ch);
      end
      for (int n = 0; n < 3; n++) begin
         tick();
         checks++;
         if (m_vld !== 1'b1 || m_ch !== 2'd1) begin
            failures++;
            $display("FAIL prio_ch1[%0d] got vld=%0b ch=%0d exp=1",
                     n, m_vld, m_ch);
         end
      end
      s_vld = '0;
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_skip();
      test_reset_mid();
`ifdef MDMA_BYP_IN_ARB_PRIO_EN
      test_prio();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
